// File: rtl/hw_irq_responder_if.sv
// hw_irq_responder_if: initiator-side bus handshake into the interrupt responder
interface hw_irq_responder_if;
    logic [31:0] hw_addr;
    logic [31:0] hw_data_i;
    logic [31:0] hw_data_o;
    logic        hw_ren;
    logic        hw_wen;
    logic        hw_ack;
    modport master (output hw_addr, hw_data_i, hw_ren, hw_wen, input hw_ack, hw_data_o);
    modport slave  (input hw_addr, hw_data_i, hw_ren, hw_wen, output hw_ack, hw_data_o);
endinterface

// File: rtl/hw_irq_responder.sv
// hw_irq_responder: I_STAT/I_MASK interrupt controller behind a latency-configurable request/ack bus
module hw_irq_responder #(
    parameter int ACK_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hw_irq_responder_if.slave    bus,
    input  logic [10:0]          irq_in,
    output logic                 irq_out
);
    typedef enum logic [1:0] {IDLE, BUSY, ACK, DONE} state_t;
    localparam logic [28:0] STAT_A = 29'h1F801070;
    localparam logic [28:0] MASK_A = 29'h1F801074;
    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic [28:0] addr_q;
    logic [10:0] data_q, irq_q, i_stat, i_mask, rise, wmask, rd;
    logic        wr_q, req, commit;
    logic        unused;
    assign unused = ^{bus.hw_addr[31:29], bus.hw_data_i[31:11]};
    always_comb begin
        req      = bus.hw_ren | bus.hw_wen;
        state_nx = state;
        state_nx = state == IDLE ? (req ? BUSY : IDLE) :
                   state == BUSY ? (cnt == 4'd0 ? ACK : BUSY) :
                   state == ACK  ? DONE : (req ? DONE : IDLE);
        commit   = state == ACK && wr_q;
        rise     = irq_in & ~irq_q;
        wmask    = commit && addr_q == STAT_A ? data_q : '1;
        rd       = addr_q == STAT_A ? i_stat : addr_q == MASK_A ? i_mask : '0;
    end
    // Set wins over a write-0 because the edge is ORed after the mask.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            wr_q          <= 1'b0;
            irq_q         <= '0;
            i_stat        <= '0;
            i_mask        <= '0;
            irq_out       <= 1'b0;
            bus.hw_ack    <= 1'b0;
            bus.hw_data_o <= '0;
        end else begin
            state      <= state_nx;
            irq_q      <= irq_in;
            i_stat     <= (i_stat & wmask) | rise;
            irq_out    <= |(i_stat & i_mask);
            bus.hw_ack <= state_nx == ACK;
            if (state == IDLE && req) begin
                addr_q <= bus.hw_addr[28:0];
                data_q <= bus.hw_data_i[10:0];
                wr_q   <= !bus.hw_ren;
                cnt    <= 4'(ACK_LATENCY - 1);
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (state == BUSY && cnt == 4'd0 && !wr_q)
                bus.hw_data_o <= {21'b0, rd};
            if (commit && addr_q == MASK_A)
                i_mask <= data_q;
        end
    end
endmodule

// File: tb/tb_hw_irq_responder.sv
// tb_hw_irq_responder: directed vector table plus hand sequences for irq timing, latency hold-off and reset abort
module tb_hw_irq_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] irq_a, irq_b;
    logic        irq_out_a, irq_out_b;
    int          total = 0;
    int          passed = 0;
    hw_irq_responder_if ia ();
    hw_irq_responder_if ib ();
    hw_irq_responder #(.ACK_LATENCY(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia), .irq_in(irq_a), .irq_out(irq_out_a));
    hw_irq_responder #(.ACK_LATENCY(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib), .irq_in(irq_b), .irq_out(irq_out_b));
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t tv[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    // op: 0 read, 1 write, 2 read+write together
    task automatic xfer(input bit sel, input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                        input logic [10:0] irq_at_ack, output logic [31:0] rd, output int lat, output logic irq_c);
        if (sel) begin
            ib.hw_addr = a; ib.hw_data_i = d; ib.hw_ren = op != 2'd1; ib.hw_wen = op != 2'd0;
        end else begin
            ia.hw_addr = a; ia.hw_data_i = d; ia.hw_ren = op != 2'd1; ia.hw_wen = op != 2'd0;
        end
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!(sel ? ib.hw_ack : ia.hw_ack) && lat < 40);
        if (lat >= 40) begin
            total++;
            $display("FAIL ack_timeout: got no ack expected ack within 40 cycles");
        end
        rd = sel ? ib.hw_data_o : ia.hw_data_o;
        irq_a = irq_a | irq_at_ack;
        ia.hw_ren = 1'b0; ia.hw_wen = 1'b0; ib.hw_ren = 1'b0; ib.hw_wen = 1'b0;
        tick();
        chk("ack_one_cycle", {31'b0, sel ? ib.hw_ack : ia.hw_ack}, 32'h0);
        irq_c = irq_out_a;
        tick();
    endtask

    initial begin
        logic [31:0] rd;
        int          lat, acks;
        logic        irq_c;
        tv[0] = '{2'd1, 32'hBF801074, 32'hFFFF_F7FF, 32'h0};
        tv[1] = '{2'd0, 32'hBF801074, 32'h0,         32'h0000_07FF};
        tv[2] = '{2'd0, 32'h1F801074, 32'h0,         32'h0000_07FF};
        tv[3] = '{2'd0, 32'h9F801074, 32'h0,         32'h0000_07FF};
        tv[4] = '{2'd1, 32'h1F801074, 32'h0000_0001, 32'h0};
        tv[5] = '{2'd2, 32'h1F801074, 32'h0000_07FF, 32'h0000_0001};
        tv[6] = '{2'd0, 32'h1F801074, 32'h0,         32'h0000_0001};
        tv[7] = '{2'd1, 32'h1F801078, 32'hFFFF_FFFF, 32'h0};
        tv[8] = '{2'd0, 32'h1F801078, 32'h0,         32'h0};
        tv[9] = '{2'd0, 32'h1F801070, 32'h0,         32'h0};
        rst_n = 1'b0;
        irq_a = '0;
        irq_b = 11'h001;
        ia.hw_addr = '0; ia.hw_data_i = '0; ia.hw_ren = 1'b0; ia.hw_wen = 1'b0;
        ib.hw_addr = '0; ib.hw_data_i = '0; ib.hw_ren = 1'b0; ib.hw_wen = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_ack", {31'b0, ia.hw_ack}, 32'h0);
        chk("rst_data", ia.hw_data_o, 32'h0);
        chk("rst_irq_out", {31'b0, irq_out_a}, 32'h0);

        for (int i = 0; i < 10; i++) begin
            xfer(1'b0, tv[i].op, tv[i].addr, tv[i].data, 11'h0, rd, lat, irq_c);
            chk($sformatf("vec%0d_latency", i), lat, 32'd2);
            if (tv[i].op != 2'd1) chk($sformatf("vec%0d_rdata", i), rd, tv[i].exp_rd);
        end

        irq_a = 11'h001;
        tick();
        chk("irq_out_lag", {31'b0, irq_out_a}, 32'h0);
        irq_a = 11'h000;
        tick();
        chk("irq_out_rise", {31'b0, irq_out_a}, 32'h1);
        xfer(1'b0, 2'd1, 32'h1F801070, 32'h0, 11'h0, rd, lat, irq_c);
        chk("irq_out_at_commit", {31'b0, irq_c}, 32'h1);
        chk("irq_out_cleared", {31'b0, irq_out_a}, 32'h0);

        xfer(1'b0, 2'd1, 32'h1F801070, 32'h0, 11'h008, rd, lat, irq_c);
        xfer(1'b0, 2'd0, 32'h1F801070, 32'h0, 11'h0, rd, lat, irq_c);
        chk("set_wins_stat", rd, 32'h0000_0008);
        xfer(1'b0, 2'd1, 32'h1F801070, 32'h0, 11'h0, rd, lat, irq_c);
        xfer(1'b0, 2'd0, 32'h1F801070, 32'h0, 11'h0, rd, lat, irq_c);
        chk("held_level_no_edge", rd, 32'h0);
        irq_a = '0;

        xfer(1'b1, 2'd0, 32'h1F801070, 32'h0, 11'h0, rd, lat, irq_c);
        chk("b_stat_latency", lat, 32'd5);
        chk("b_stat_rdata", rd, 32'h0000_0001);
        xfer(1'b1, 2'd0, 32'h9F801000, 32'h0, 11'h0, rd, lat, irq_c);
        chk("b_unmapped_latency", lat, 32'd5);
        chk("b_unmapped_rdata", rd, 32'h0);

        ib.hw_addr = 32'h9F801000;
        ib.hw_ren = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!ib.hw_ack && lat < 40);
        chk("b_hold_first_latency", lat, 32'd5);
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ib.hw_ack) acks++;
        end
        chk("b_hold_no_reaccept", acks, 32'd0);
        ib.hw_ren = 1'b0;
        tick();
        ib.hw_ren = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!ib.hw_ack && lat < 40);
        chk("b_reaccept_latency", lat, 32'd5);
        ib.hw_ren = 1'b0;
        tick();
        tick();

        irq_a = 11'h020;
        tick();
        ia.hw_addr = 32'h1F801074; ia.hw_data_i = 32'h0000_07FF; ia.hw_wen = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        chk("abort_ack_in_reset", {31'b0, ia.hw_ack}, 32'h0);
        rst_n = 1'b1;
        ia.hw_wen = 1'b0;
        tick();
        chk("abort_ack_after", {31'b0, ia.hw_ack}, 32'h0);
        xfer(1'b0, 2'd0, 32'h1F801074, 32'h0, 11'h0, rd, lat, irq_c);
        chk("abort_mask_latency", lat, 32'd2);
        chk("abort_mask_clear", rd, 32'h0);
        xfer(1'b0, 2'd0, 32'h1F801070, 32'h0, 11'h0, rd, lat, irq_c);
        chk("post_reset_level_edge", rd, 32'h0000_0020);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/hw_irq_responder.md
HW_IRQ_RESPONDER -- requirements
Module: hw_irq_responder

Interface
REQ-001 SHALL have parameter ACK_LATENCY, default 1: cycles from request accept to hw_ack pulse; legal range 1..15.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port hw_addr, input, 32: byte address from the initiator.
REQ-005 SHALL have port hw_data_i, input, 32: write data from the initiator.
REQ-006 SHALL have port hw_ren, input, 1: read request; held high by the initiator until hw_ack.
REQ-007 SHALL have port hw_wen, input, 1: write request; held high by the initiator until hw_ack.
REQ-008 SHALL have port hw_ack, output, 1: one-cycle completion pulse.
REQ-009 SHALL have port hw_data_o, output, 32: read data; valid in the hw_ack cycle.
REQ-010 SHALL have port irq_in, input, 11: peripheral interrupt lines, active-high level.
REQ-011 SHALL have port irq_out, output, 1: CPU interrupt request.

Function
REQ-012 SHALL decode on hw_addr[28:0] only, so KUSEG, KSEG0 and KSEG1 mirrors alias: 29'h1F801070 is I_STAT and 29'h1F801074 is I_MASK.
REQ-013 SHALL implement FSM states IDLE, BUSY, ACK and DONE.
REQ-014 SHALL transition IDLE->BUSY when hw_ren or hw_wen is high; latch addr, data and op (read if hw_ren, else write) and load the latency counter with ACK_LATENCY-1.
REQ-015 SHALL give hw_ren priority when hw_ren and hw_wen are high together: the access is a read and the write is dropped.
REQ-016 SHALL transition BUSY->ACK when the counter is 0, else decrement; hw_ack therefore rises exactly ACK_LATENCY+1 cycles after the accept edge.
REQ-017 SHALL assert hw_ack in ACK for exactly one cycle, then enter DONE.
REQ-018 SHALL transition DONE->IDLE only in a cycle where hw_ren and hw_wen are both low; a new request therefore needs at least one idle-low cycle.
REQ-019 SHALL commit a write on the ACK cycle edge using the latched address and data.
REQ-020 SHALL, for a read, load hw_data_o on entry to ACK with {21'b0, reg[10:0]} and hold it until the next read completes.
REQ-021 SHALL read unmapped addresses as 32'h0, ignore writes to them, and still acknowledge them (bus never hangs).
REQ-022 SHALL register irq_in into irq_q each cycle; a rising edge is irq_in & ~irq_q.
REQ-023 SHALL update I_STAT as next = (stat & wmask) | edge, where wmask = latched data[10:0] on an I_STAT commit cycle and all-ones otherwise.
REQ-024 SHALL, on a same-cycle edge and write-0 to the same bit, leave the bit set (set wins).
REQ-025 SHALL load I_MASK with latched data[10:0] on an I_MASK write commit; bits [31:11] are ignored.
REQ-026 SHALL register irq_out = |(I_STAT & I_MASK), so it lags the register state by one cycle.
REQ-027 SHALL not generate a new edge from a level held high; it must fall and rise again.
REQ-028 SHALL treat requests arriving in BUSY, ACK or DONE as the current transaction; no queueing.

Reset
REQ-029 SHALL, in a cycle with rst_n low, set FSM to IDLE and clear hw_ack, hw_data_o, I_STAT, I_MASK, irq_q and irq_out.
REQ-030 SHALL abandon a transaction in progress at reset: no commit, no ack; the first post-reset cycle starts in IDLE.
REQ-031 SHALL, on the first cycle after reset release, treat any irq_in bit already high as a rising edge and set it in I_STAT.

Verification
REQ-032 Read I_MASK after writing 32'hFFFF_F7FF to 32'hBF801074, ACK_LATENCY=1 -> hw_ack 2 cycles after accept, hw_data_o=32'h0000_07FF.
REQ-033 Pulse irq_in[0] with I_MASK=1 -> I_STAT=1 next cycle, irq_out=1 the cycle after; write 32'h0 to 0x1F801070 -> irq_out=0 two cycles after commit.
REQ-034 Write 32'h0 to I_STAT in the same cycle an irq_in[3] edge occurs -> I_STAT bit3=1.
REQ-035 Read 0x9F801000 (unmapped) with ACK_LATENCY=4 -> hw_ack 5 cycles after accept, data 32'h0; a new request with hw_ren held high through DONE is not accepted until hw_ren goes low for one cycle.
REQ-036 Drop rst_n during BUSY of a write to I_MASK -> no hw_ack, I_MASK=0, FSM in IDLE the cycle after release.
